sort_stream: RTL and testbench
==============================

# sort_stream

Serial-interface counterpart of the team's parallel sorter. It accepts N elements one per handshake on a valid/ready input stream and sorts them in place over N cycles of odd-even transposition. It then emits the sorted elements one per handshake on a valid/ready output stream, marking the final element with `o_last`. It sits between byte-serial producers and consumers that cannot supply or absorb a full N-wide vector in one cycle.

## Interface
- `N`, 4: elements per frame; legal range 2..64, odd or even.
- `W`, 8: element width in bits.
- `P`, 1: sort order; 0 = ascending, 1 = descending.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_data`  in  W  input element.
- `i_valid`  in  1  `i_data` is valid.
- `o_ready`  out  1  block can accept an element.
- `o_data`  out  W  output element.
- `o_valid`  out  1  `o_data` is valid.
- `i_ready`  in  1  downstream accepts `o_data`.
- `o_last`  out  1  current output element is element N-1 of the frame.

## Operation
- Storage: N×W register buffer `buf`, plus index counter `idx` (clog2(N) bits) and pass counter `pass` (clog2(N+1) bits).
- The FSM has three states: LOAD, SORT, DRAIN. Reset state is LOAD.
- LOAD:
  - `o_ready`=1, `o_valid`=0.
  - On `i_valid & o_ready`, write `buf[idx]` ← `i_data` and increment `idx`.
  - On the accept where `idx`==N-1, set `idx` ← 0 and `pass` ← 0, then go to SORT.
- SORT:
  - `o_ready`=0, `o_valid`=0.
  - Each cycle runs one pass over disjoint pairs (j, j+1), in parallel.
  - Even `pass`: j = 0, 2, 4, …
  - Odd `pass`: j = 1, 3, 5, …
  - Swap condition: `buf[j] > buf[j+1]` when P=0; `buf[j] < buf[j+1]` when P=1.
  - Equal elements are never swapped.
  - Odd N: the unpaired end element is untouched in that pass.
  - Increment `pass`. When `pass`==N-1 completes, go to DRAIN.
  - Exactly N passes are run; no early exit.
- DRAIN:
  - `o_valid`=1, `o_data`=`buf[idx]`, `o_last`=(`idx`==N-1).
  - On `o_valid & i_ready`, increment `idx`.
  - On the handshake where `o_last`=1, set `idx` ← 0 and return to LOAD.
- Comparisons are unsigned W-bit. No arithmetic widening.
- `i_valid` in SORT or DRAIN is ignored; no data is lost because `o_ready`=0.
- `i_data` is don't-care when `i_valid`=0.

## Timing
- Reset values:
  - `o_valid`=0, `o_last`=0, `o_data`=0 (buffer cleared), `o_ready`=1.
  - `idx`=0, `pass`=0, state LOAD.
- Reset mid-frame (any state) discards the partial frame; the block returns to LOAD with all of the above values.
- `o_ready`, `o_valid`, `o_last` are decoded from registered state only. There is no combinational path from `i_valid` or `i_ready` to any output.
- Latency:
  - Let E be the edge of the final input handshake.
  - Passes execute at edges E+1..E+N.
  - `o_valid` rises after edge E+N.
- Throughput: one frame per N (load) + N (sort) + N (drain, with `i_ready` held high) cycles.
- Load and drain do not overlap.
- Backpressure: while `o_valid`=1 and `i_ready`=0, `o_data` and `o_last` hold stable.
- `o_ready` rises the cycle after the last output handshake. Back-to-back frames then incur no bubble beyond this.

## Structure
- Package `sort_pkg`:
  - `state_e` enum {LOAD, SORT, DRAIN}.
  - Function `cas_swap(a, b, p)` returning the swap decision.
  - Localparams for `IDX_W` = clog2(N) and `PASS_W` = clog2(N+1).
- Sub-module `sort_cas`: W-bit compare-and-swap cell (inputs a, b, P; outputs lo/hi-ordered pair).
  - Instantiated N/2 times for the even-phase pairs and (N-1)/2 times for the odd-phase pairs.
  - The pass parity muxes which result set is written back.
- Top level holds the FSM, counters and buffer.

## Test plan
- Reset then idle: `o_ready`=1, `o_valid`=0, `o_data`=0; holding `i_valid`=0 for 20 cycles changes nothing.
- N=4, P=1, inputs 3, 9, 1, 7 back-to-back → outputs 9, 7, 3, 1, with `o_last` only on 1; first `o_valid` exactly 4 cycles after the last input accept.
- N=4, P=0, inputs 255, 0, 255, 0 → outputs 0, 0, 255, 255 (unsigned compare, duplicates kept).
- N=5 (odd), P=1, reverse-sorted worst case 1, 2, 3, 4, 5 → outputs 5, 4, 3, 2, 1; `o_valid` 5 cycles after the last accept.
- Backpressure: `i_ready` toggling 1, 0, 0, 1, … during DRAIN → `o_data` stable while stalled and each element emitted exactly once; `i_valid` held high during SORT/DRAIN must not corrupt the frame; the next frame loads correctly afterward.
- Async reset asserted mid-SORT and mid-DRAIN → outputs go to reset values immediately; a following fresh frame 4, 4, 2, 8 (P=1) → 8, 4, 4, 2.

Source files
------------

// File: rtl/sort_pkg.sv
// ---------------------------------------------------------------------------
// sort_pkg
// Shared types and helpers for the serial odd-even transposition sorter.
//   state_e      : FSM states (LOAD accepts input, SORT runs passes,
//                  DRAIN emits results).
//   IDX_W/PASS_W : counter widths for the default frame size of 4.
//   idx_width()  : element-index counter width for an arbitrary frame size.
//   pass_width() : pass counter width; it must be able to hold the value N.
//   cas_swap()   : decides whether an adjacent pair is out of order.
// ---------------------------------------------------------------------------
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DEFAULT_N = 4;
    localparam int IDX_W     = $clog2(DEFAULT_N);
    localparam int PASS_W    = $clog2(DEFAULT_N + 1);

    // Widest element the compare helper handles. Narrower elements are
    // zero-extended, which keeps the comparison unsigned.
    localparam int MAX_W = 64;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int pass_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Returns 1 when a (lower position) and b (upper position) must be
    // exchanged. p = 0 orders ascending and p = 1 orders descending. Equal
    // values never swap, so duplicates keep their relative order.
    function automatic logic cas_swap(input logic [MAX_W-1:0] a,
                                      input logic [MAX_W-1:0] b,
                                      input logic             p);
        return p ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/sort_cas.sv
// ---------------------------------------------------------------------------
// sort_cas
// Compare-and-swap cell for one adjacent pair of the sort buffer.
//   W  : element width
//   P  : sort order (0 ascending, 1 descending)
//   a  : element at the lower buffer position
//   b  : element at the upper buffer position
//   lo : value to write back to the lower position
//   hi : value to write back to the upper position
// ---------------------------------------------------------------------------
module sort_cas
    import sort_pkg::*;
#(
    parameter int W = 8,
    parameter bit P = 1'b0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic swap;

    always_comb begin
        swap = cas_swap(MAX_W'(a), MAX_W'(b), P);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/sort_stream.sv
// ---------------------------------------------------------------------------
// sort_stream
// Collects N elements from a valid/ready stream, sorts them in place with N
// passes of odd-even transposition, then streams them out one per handshake.
//   N, W, P  : frame size, element width, order (0 ascending, 1 descending)
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_data   : input element, taken when i_valid and o_ready are both high
//   i_valid  : input element valid
//   o_ready  : block is in LOAD and can take an element
//   o_data   : output element (buffer entry at the current index)
//   o_valid  : output element valid (DRAIN)
//   i_ready  : downstream takes o_data
//   o_last   : current output is the final element of the frame
// ---------------------------------------------------------------------------
module sort_stream
    import sort_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    parameter int P = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_last
);

    localparam int IW    = idx_width(N);
    localparam int PW    = pass_width(N);
    localparam int NE    = N / 2;
    localparam int NO    = (N - 1) / 2;
    localparam int NO_SZ = (NO > 0) ? NO : 1;
    localparam bit ORDER = (P != 0);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   pass_q, pass_d;
    logic [W-1:0]    buf_q [N];
    logic [W-1:0]    buf_d [N];
    logic [W-1:0]    pass_res [N];

    logic [W-1:0]    even_lo [NE];
    logic [W-1:0]    even_hi [NE];
    logic [W-1:0]    odd_lo  [NO_SZ];
    logic [W-1:0]    odd_hi  [NO_SZ];

    logic            last_idx;

    // Even-phase cells cover pairs (0,1), (2,3), ...
    for (genvar k = 0; k < NE; k++) begin : g_even
        sort_cas #(.W(W), .P(ORDER)) u_cas (
            .a  (buf_q[2*k]),
            .b  (buf_q[2*k+1]),
            .lo (even_lo[k]),
            .hi (even_hi[k])
        );
    end

    // Odd-phase cells cover pairs (1,2), (3,4), ...
    if (NO > 0) begin : g_odd_cells
        for (genvar k = 0; k < NO; k++) begin : g_odd
            sort_cas #(.W(W), .P(ORDER)) u_cas (
                .a  (buf_q[2*k+1]),
                .b  (buf_q[2*k+2]),
                .lo (odd_lo[k]),
                .hi (odd_hi[k])
            );
        end
    end else begin : g_no_odd
        assign odd_lo[0] = '0;
        assign odd_hi[0] = '0;
    end

    // Pass parity picks which cell set writes back; any element outside the
    // chosen pairs (ends of the buffer) keeps its current value.
    always_comb begin
        pass_res = buf_q;
        if (!pass_q[0]) begin
            for (int k = 0; k < NE; k++) begin
                pass_res[2*k]   = even_lo[k];
                pass_res[2*k+1] = even_hi[k];
            end
        end else begin
            for (int k = 0; k < NO; k++) begin
                pass_res[2*k+1] = odd_lo[k];
                pass_res[2*k+2] = odd_hi[k];
            end
        end
    end

    assign last_idx = (idx_q == IW'(N - 1));

    // Next-state logic for the FSM, counters and buffer. LOAD and DRAIN share
    // the index counter; SORT always runs exactly N passes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        buf_d   = buf_q;
        unique case (state_q)
            LOAD: begin
                if (i_valid) begin
                    buf_d[idx_q] = i_data;
                    if (last_idx) begin
                        idx_d   = '0;
                        pass_d  = '0;
                        state_d = SORT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SORT: begin
                buf_d  = pass_res;
                pass_d = pass_q + 1'b1;
                if (pass_q == PW'(N - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (i_ready) begin
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Outputs come only from registered state so that neither handshake
    // input has a combinational path to an output.
    always_comb begin
        o_ready = (state_q == LOAD);
        o_valid = (state_q == DRAIN);
        o_last  = (state_q == DRAIN) && last_idx;
        o_data  = buf_q[idx_q];
    end

    // Reset clears the buffer as well, so o_data reads zero out of reset and
    // a reset mid-frame leaves no stale elements visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= LOAD;
            idx_q   <= '0;
            pass_q  <= '0;
            for (int k = 0; k < N; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_sort_stream.sv
// ---------------------------------------------------------------------------
// tb_sort_stream
// Drives three sorter instances (N=4 descending, N=4 ascending, N=5
// descending) and compares every output against a queue-sort reference.
// ---------------------------------------------------------------------------
module tb_sort_stream;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data   [3];
    logic       in_valid  [3];
    logic       dut_ready [3];
    logic [7:0] out_data  [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic       out_last  [3];

    int checks = 0;
    int errors = 0;

    sort_stream #(.N(4), .W(8), .P(1)) u_desc4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (in_data[0]),
        .i_valid (in_valid[0]),
        .o_ready (dut_ready[0]),
        .o_data  (out_data[0]),
        .o_valid (out_valid[0]),
        .i_ready (out_ready[0]),
        .o_last  (out_last[0])
    );

    sort_stream #(.N(4), .W(8), .P(0)) u_asc4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (in_data[1]),
        .i_valid (in_valid[1]),
        .o_ready (dut_ready[1]),
        .o_data  (out_data[1]),
        .o_valid (out_valid[1]),
        .i_ready (out_ready[1]),
        .o_last  (out_last[1])
    );

    sort_stream #(.N(5), .W(8), .P(1)) u_desc5 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (in_data[2]),
        .i_valid (in_valid[2]),
        .o_ready (dut_ready[2]),
        .o_data  (out_data[2]),
        .o_valid (out_valid[2]),
        .i_ready (out_ready[2]),
        .o_last  (out_last[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int frame_len(input int d);
        return (d == 2) ? 5 : 4;
    endfunction

    function automatic bit frame_desc(input int d);
        return (d != 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic checkIdle(input int d, input string tag);
        checkOutput({tag, "_ready"}, 32'(dut_ready[d]), 32'd1);
        checkOutput({tag, "_valid"}, 32'(out_valid[d]), 32'd0);
        checkOutput({tag, "_last"},  32'(out_last[d]),  32'd0);
        checkOutput({tag, "_data"},  32'(out_data[d]),  32'd0);
    endtask

    // Feeds a frame back-to-back; returns one time unit after the final
    // accepting edge.
    task automatic loadFrame(input int d, input int vals[$]);
        foreach (vals[i]) begin
            in_valid[d] = 1'b1;
            in_data[d]  = 8'(vals[i]);
            checkOutput("load_ready", 32'(dut_ready[d]), 32'd1);
            checkOutput("load_valid", 32'(out_valid[d]), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0;
    endtask

    // Full frame: load, sort latency, drain against the reference ordering.
    // bp_mode 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
    task automatic applyStimulus(input int d, input int vals[$],
                                 input bit hold_valid, input int bp_mode);
        int n;
        int expq[$];
        int lat;
        int k;
        int cyc;
        bit r;
        n    = frame_len(d);
        expq = vals;
        if (frame_desc(d)) expq.rsort();
        else               expq.sort();

        loadFrame(d, vals);
        if (hold_valid) begin
            in_valid[d] = 1'b1;
            in_data[d]  = 8'($urandom_range(0, 255));
        end
        checkOutput("sort_ready_low", 32'(dut_ready[d]), 32'd0);
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (hold_valid) in_data[d] = 8'($urandom_range(0, 255));
        end
        checkOutput("latency", 32'(lat), 32'(n));

        k   = 0;
        cyc = 0;
        while (k < n && cyc < 200) begin
            case (bp_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready[d] = r;
            checkOutput("drain_valid", 32'(out_valid[d]), 32'd1);
            checkOutput("drain_ready_low", 32'(dut_ready[d]), 32'd0);
            checkOutput("drain_data", 32'(out_data[d]), 32'(expq[k]));
            checkOutput("drain_last", 32'(out_last[d]), 32'(k == n - 1));
            @(posedge clk);
            #1;
            if (hold_valid) in_data[d] = 8'($urandom_range(0, 255));
            if (r) k++;
            cyc++;
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        checkOutput("drain_done", 32'(k), 32'(n));
        checkOutput("post_valid", 32'(out_valid[d]), 32'd0);
        checkOutput("post_ready", 32'(dut_ready[d]), 32'd1);
    endtask

    task automatic randomFrame(input int d, input bit narrow);
        int vals[$];
        vals = {};
        for (int i = 0; i < frame_len(d); i++) begin
            vals.push_back(narrow ? int'($urandom_range(0, 3))
                                  : int'($urandom_range(0, 255)));
        end
        applyStimulus(d, vals, 1'($urandom_range(0, 1)), 2);
    endtask

    initial begin
        int lat;
        for (int d = 0; d < 3; d++) begin
            in_data[d]   = '0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] reset and idle");
        for (int d = 0; d < 3; d++) checkIdle(d, "reset");
        for (int c = 0; c < 20; c++) begin
            in_data[0] = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        checkIdle(0, "idle20");

        $display("[TB] directed frames");
        applyStimulus(0, {3, 9, 1, 7}, 1'b0, 0);
        applyStimulus(1, {255, 0, 255, 0}, 1'b0, 0);
        applyStimulus(2, {1, 2, 3, 4, 5}, 1'b0, 0);

        $display("[TB] backpressure with i_valid held");
        applyStimulus(0, {10, 200, 30, 30}, 1'b1, 1);
        applyStimulus(0, {5, 6, 7, 8}, 1'b0, 0);
        applyStimulus(2, {9, 0, 9, 4, 250}, 1'b1, 1);

        $display("[TB] reset mid-SORT");
        loadFrame(0, {11, 22, 33, 44});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle(0, "rst_sort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkIdle(0, "rst_sort_rel");

        $display("[TB] reset mid-DRAIN");
        loadFrame(0, {50, 60, 70, 80});
        lat = 0;
        while (out_valid[0] !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("rst_drain_reach", 32'(out_valid[0]), 32'd1);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        checkOutput("rst_drain_second", 32'(out_data[0]), 32'd70);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle(0, "rst_drain");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, {4, 4, 2, 8}, 1'b0, 0);

        $display("[TB] random frames");
        for (int f = 0; f < 4; f++) begin
            for (int d = 0; d < 3; d++) begin
                randomFrame(d, f[0]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
